rv32_pc_fetch: RTL and testbench
================================

// Module: rv32_pc_fetch
// PURPOSE
//  Per-hart program-counter file and instruction-fetch issue stage of the barrel pipeline.
//  Sits directly downstream of the next-PC stage: consumes its redirect (next_pc_val/has_new_pc) per hart.
//  Issues one instruction-memory read per cycle, round-robin over harts.
//  Delivers the fetched hart id and PC aligned with the 1-cycle-latency imem read data.
// PARAMETERS
//  NUM_HARTS  8           number of hardware threads; power of 2, >=2
//  PC_W       32          PC width in bits
//  IMEM_AW    12          imem word-address width; imem_addr = pc[IMEM_AW+1:2]
//  RESET_PC   32'h0       boot PC loaded into every hart at reset
// PORTS
//  clk             in   1                  clock, all logic on rising edge
//  rst_n           in   1                  synchronous, active-low reset
//  start           in   1                  leave IDLE and begin fetching (level or pulse)
//  stall           in   1                  freeze fetch issue this cycle
//  redir_valid     in   1                  next-PC result present for redir_hart
//  redir_hart      in   $clog2(NUM_HARTS)  hart the result belongs to
//  redir_taken     in   1                  has_new_pc: redir_pc replaces sequential PC
//  redir_pc        in   PC_W               next_pc_val from next-PC stage
//  imem_req        out  1                  imem read strobe
//  imem_addr       out  IMEM_AW            imem word address
//  fetch_valid     out  1                  imem data this cycle belongs to fetch_hart/fetch_pc
//  fetch_hart      out  $clog2(NUM_HARTS)  hart of returning instruction
//  fetch_pc        out  PC_W               byte PC of returning instruction
//  misalign_err    out  1                  1-cycle pulse: accepted redir_pc had [1:0]!=0
//  running         out  1                  FSM in RUN or STALL
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): pc[h]=RESET_PC for all h, hart_cnt=0, state=IDLE;
//   imem_req, imem_addr, fetch_valid, fetch_hart, fetch_pc, misalign_err, running all 0.
//  FSM: IDLE -start-> RUN; RUN -stall-> STALL; STALL -!stall-> RUN. No exit except reset.
//   IDLE: imem_req=0; redirects accepted. running=0.
//  RUN (stall=0), per cycle, h=hart_cnt:
//   pc_eff = (redir hit on h) ? {redir_pc[PC_W-1:2],2'b00} : pc[h]
//   imem_req=1 and imem_addr=pc_eff[IMEM_AW+1:2], combinational from state
//   pc[h] <= pc_eff+4 (mod 2^PC_W); hart_cnt <= hart_cnt+1, wraps NUM_HARTS-1 -> 0
//   next cycle: fetch_valid=1, fetch_hart=h, fetch_pc=pc_eff (1-cycle latency)
//  STALL, or stall=1 in RUN: imem_req=0; hart_cnt and issue frozen; fetch_valid=0 next cycle;
//   fetch_hart/fetch_pc hold. Stall is seen same cycle: no request issued while stall=1.
//  Redirect (any state): redir_valid & redir_taken -> pc[redir_hart] <= {redir_pc[PC_W-1:2],2'b00}.
//   redir_valid & !redir_taken -> no PC change (sequential PC already advanced at issue).
//   misalign_err=1 next cycle iff accepted redirect had redir_pc[1:0]!=0; else 0.
//  Collision: redirect to the hart issued this cycle -> bypass (pc_eff above);
//   issue uses redirected PC, pc[h] <= redirected PC + 4. Redirect always beats increment.
//  Redirect to a non-issuing hart: written the same edge; no interaction.
//  Reset mid-operation: all state returns to reset values at the edge; in-flight fetch discarded
//   (fetch_valid=0 next cycle).
//  Requirement on pipeline: redirect for hart h arrives before h's next issue slot
//   (pipeline depth < NUM_HARTS); later redirects are applied but a wrong-path fetch has issued.
// TESTING
//  1 Reset, start; 16 cycles no stall -> harts 0..7,0..7; fetch_pc 0x0 then 0x4; imem_addr 0,1.
//  2 Hart 3 redirect redir_taken=1 redir_pc=0x100 -> hart 3 next fetch_pc=0x100, then 0x104.
//  3 Redirect hart 2 in its issue cycle, pc=0x200 -> imem_addr=0x80 same cycle; next hart 2 pc=0x204.
//  4 stall 3 cycles mid-round at hart 5 -> imem_req=0 x3, fetch_valid=0 x3; resume at hart 5, PC unchanged.
//  5 redir_pc=0x102 taken -> misalign_err pulse 1 cycle; hart fetches 0x100.
//  6 pc[0]=0xFFFFFFFC issue -> next pc 0x0; assert rst_n=0 mid-round -> all pcs RESET_PC, state IDLE.

Source files
------------

// File: rtl/rv32_pc_fetch.sv
// Per-hart program-counter file and round-robin instruction-fetch issue stage.
// Issues one imem read per cycle and returns hart/PC aligned with the 1-cycle imem data.
module rv32_pc_fetch #(
  parameter int                NUM_HARTS = 8,
  parameter int                PC_W      = 32,
  parameter int                IMEM_AW   = 12,
  parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         redir_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] redir_hart,
  input  logic                         redir_taken,
  input  logic [PC_W-1:0]              redir_pc,
  output logic                         imem_req,
  output logic [IMEM_AW-1:0]           imem_addr,
  output logic                         fetch_valid,
  output logic [$clog2(NUM_HARTS)-1:0] fetch_hart,
  output logic [PC_W-1:0]              fetch_pc,
  output logic                         misalign_err,
  output logic                         running
);

  localparam int HW = $clog2(NUM_HARTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                        state_reg;
  logic                          running_reg;
  logic [HW-1:0]                 hart_cnt_reg;
  logic                          fetch_valid_reg;
  logic [HW-1:0]                 fetch_hart_reg;
  logic [PC_W-1:0]               fetch_pc_reg;
  logic                          misalign_err_reg;
  logic [NUM_HARTS-1:0][PC_W-1:0] pc_file;

  logic                          issue;
  logic                          redir_wr;
  logic                          redir_hit;
  logic [PC_W-1:0]               redir_pc_aligned;
  logic [PC_W-1:0]               pc_eff;
  logic [PC_W-1:0]               pc_next_seq;

  // Stall is honoured in the same cycle it is raised, so the STALL state only
  // tracks status; issue depends on the live stall input.
  assign issue            = rst_n && (state_reg != IDLE) && !stall;
  assign redir_wr         = redir_valid && redir_taken;
  assign redir_hit        = redir_wr && (redir_hart == hart_cnt_reg);
  assign redir_pc_aligned = {redir_pc[PC_W-1:2], 2'b00};
  assign pc_eff           = redir_hit ? redir_pc_aligned : pc_file[hart_cnt_reg];
  assign pc_next_seq      = pc_eff + PC_W'(4);

  assign imem_req     = issue;
  assign imem_addr    = issue ? pc_eff[IMEM_AW+1:2] : '0;
  assign fetch_valid  = fetch_valid_reg;
  assign fetch_hart   = fetch_hart_reg;
  assign fetch_pc     = fetch_pc_reg;
  assign misalign_err = misalign_err_reg;
  assign running      = running_reg;

  // One PC register per hart; the issuing hart's update already folds in any
  // same-cycle redirect through pc_eff, so it takes priority here.
  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_pc
    logic [PC_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pc_reg <= RESET_PC;
      end else if (issue && (hart_cnt_reg == HW'(gi))) begin
        pc_reg <= pc_next_seq;
      end else if (redir_wr && (redir_hart == HW'(gi))) begin
        pc_reg <= redir_pc_aligned;
      end
    end

    assign pc_file[gi] = pc_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          if (stall) state_reg <= STALL;
        end
        STALL: begin
          if (!stall) state_reg <= RUN;
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hart_cnt_reg     <= '0;
      fetch_valid_reg  <= 1'b0;
      fetch_hart_reg   <= '0;
      fetch_pc_reg     <= '0;
      misalign_err_reg <= 1'b0;
    end else begin
      fetch_valid_reg  <= issue;
      misalign_err_reg <= redir_wr && (redir_pc[1:0] != 2'b00);
      if (issue) begin
        hart_cnt_reg   <= hart_cnt_reg + HW'(1);
        fetch_hart_reg <= hart_cnt_reg;
        fetch_pc_reg   <= pc_eff;
      end
    end
  end

endmodule

// File: tb/tb_rv32_pc_fetch.sv
// Scoreboard bench for rv32_pc_fetch: a reference model predicts each issued
// fetch, a monitor pops and compares it when fetch_valid returns.
module tb_rv32_pc_fetch;

  localparam int NH = 8;
  localparam int PW = 32;
  localparam int AW = 12;
  localparam int HW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          redir_valid = 1'b0;
  logic [HW-1:0] redir_hart = '0;
  logic          redir_taken = 1'b0;
  logic [PW-1:0] redir_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          fetch_valid;
  logic [HW-1:0] fetch_hart;
  logic [PW-1:0] fetch_pc;
  logic          misalign_err;
  logic          running;

  rv32_pc_fetch #(
    .NUM_HARTS(NH), .PC_W(PW), .IMEM_AW(AW), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .redir_valid(redir_valid), .redir_hart(redir_hart),
    .redir_taken(redir_taken), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .fetch_valid(fetch_valid), .fetch_hart(fetch_hart), .fetch_pc(fetch_pc),
    .misalign_err(misalign_err), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [PW-1:0] pc;
  } fetch_t;

  int            n_cmp = 0;
  int            n_err = 0;
  fetch_t        sb[$];
  fetch_t        mon_exp;
  logic [PW-1:0] m_pc[NH];
  int            m_cnt = 0;
  bit            m_run = 1'b0;

  logic          obs_req, exp_req;
  logic [AW-1:0] obs_addr, exp_addr;

  // Scoreboard monitor: every returning fetch must match the oldest prediction.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got hart=%0d pc=%h, required no fetch", fetch_hart, fetch_pc);
      end else begin
        mon_exp = sb.pop_front();
        if (fetch_hart !== mon_exp.hart || fetch_pc !== mon_exp.pc) begin
          n_err++;
          $display("FAIL sb_fetch: got hart=%0d pc=%h, required hart=%0d pc=%h",
                   fetch_hart, fetch_pc, mon_exp.hart, mon_exp.pc);
        end else begin
          $display("fetch hart=%0d pc=%h ok", fetch_hart, fetch_pc);
        end
      end
    end
  end

  // Advance one cycle: sample combinational outputs, update the model, push predictions.
  task automatic step();
    logic [PW-1:0] eff;
    logic          hit;
    logic          iss;
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    iss  = m_run && !stall && rst_n;
    hit  = redir_valid && redir_taken && (redir_hart == HW'(m_cnt));
    eff  = hit ? {redir_pc[PW-1:2], 2'b00} : m_pc[m_cnt];
    exp_req  = iss;
    exp_addr = iss ? eff[AW+1:2] : '0;
    if (!rst_n) begin
      for (int i = 0; i < NH; i++) m_pc[i] = 32'h0;
      m_cnt = 0;
      m_run = 1'b0;
      sb.delete();
    end else begin
      if (redir_valid && redir_taken) m_pc[redir_hart] = {redir_pc[PW-1:2], 2'b00};
      if (iss) begin
        sb.push_back({HW'(m_cnt), eff});
        m_pc[m_cnt] = eff + 32'd4;
        m_cnt = (m_cnt + 1) % NH;
      end
      if (!m_run && start) m_run = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== '0) begin
      n_err++;
      $display("FAIL reset_imem: got req=%b addr=%h, required 0/0", imem_req, imem_addr);
    end
    n_cmp++;
    if (fetch_valid !== 1'b0 || fetch_hart !== '0 || fetch_pc !== '0) begin
      n_err++;
      $display("FAIL reset_fetch: got v=%b h=%0d pc=%h, required 0/0/0", fetch_valid, fetch_hart, fetch_pc);
    end
    n_cmp++;
    if (running !== 1'b0 || misalign_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: got running=%b misalign=%b, required 0/0", running, misalign_err);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs_req !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_start: got req=%b running=%b, required 0/0", obs_req, running);
    end
    $display("reset checks done");
  endtask

  task automatic test_sequential();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (running !== 1'b1) begin
      n_err++;
      $display("FAIL start_running: got %b, required 1", running);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (obs_req !== 1'b1 || obs_addr !== AW'(i < 8 ? 0 : 1)) begin
        n_err++;
        $display("FAIL seq_issue[%0d]: got req=%b addr=%h, required 1/%h", i, obs_req, obs_addr, AW'(i < 8 ? 0 : 1));
      end
    end
  endtask

  task automatic test_redirect();
    int h;
    int seen = 0;
    redir_valid = 1'b1; redir_taken = 1'b1; redir_hart = 3'd3; redir_pc = 32'h100;
    step();
    redir_valid = 1'b0; redir_taken = 1'b0;
    for (int i = 0; i < 12; i++) begin
      h = m_cnt;
      step();
      if (h == 3) begin
        n_cmp++;
        if (obs_addr !== (seen == 0 ? 12'h040 : 12'h041)) begin
          n_err++;
          $display("FAIL redir_addr[%0d]: got %h, required %h", seen, obs_addr, seen == 0 ? 12'h040 : 12'h041);
        end
        seen++;
      end
    end
  endtask

  task automatic test_collision();
    int h;
    for (int i = 0; i < NH && m_cnt != 2; i++) step();
    redir_valid = 1'b1; redir_taken = 1'b1; redir_hart = 3'd2; redir_pc = 32'h200;
    step();
    redir_valid = 1'b0; redir_taken = 1'b0;
    n_cmp++;
    if (obs_req !== 1'b1 || obs_addr !== 12'h080) begin
      n_err++;
      $display("FAIL collide_bypass: got req=%b addr=%h, required 1/080", obs_req, obs_addr);
    end
    for (int i = 0; i < NH; i++) begin
      h = m_cnt;
      step();
      if (h == 2) begin
        n_cmp++;
        if (obs_addr !== 12'h081) begin
          n_err++;
          $display("FAIL collide_next: got %h, required 081", obs_addr);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] pc5;
    for (int i = 0; i < NH && m_cnt != 5; i++) step();
    pc5 = m_pc[5];
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs_req !== 1'b0 || fetch_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d]: got req=%b fetch_valid=%b, required 0/0", i, obs_req, fetch_valid);
      end
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (obs_req !== 1'b1 || obs_addr !== pc5[AW+1:2] || fetch_hart !== 3'd5) begin
      n_err++;
      $display("FAIL stall_resume: got req=%b addr=%h hart=%0d, required 1/%h/5", obs_req, obs_addr, fetch_hart, pc5[AW+1:2]);
    end
  endtask

  task automatic test_misalign();
    int tgt;
    int h;
    tgt = (m_cnt + 4) % NH;
    redir_valid = 1'b1; redir_taken = 1'b1; redir_hart = HW'(tgt); redir_pc = 32'h102;
    step();
    redir_taken = 1'b0; redir_hart = HW'((tgt + 2) % NH); redir_pc = 32'h303;
    n_cmp++;
    if (misalign_err !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_pulse: got %b, required 1", misalign_err);
    end
    step();
    redir_valid = 1'b0;
    n_cmp++;
    if (misalign_err !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_not_taken: got %b, required 0", misalign_err);
    end
    for (int i = 0; i < NH; i++) begin
      h = m_cnt;
      step();
      if (h == tgt) begin
        n_cmp++;
        if (obs_addr !== 12'h040) begin
          n_err++;
          $display("FAIL misalign_addr: got %h, required 040", obs_addr);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    int h;
    for (int i = 0; i < NH && m_cnt != 0; i++) step();
    redir_valid = 1'b1; redir_taken = 1'b1; redir_hart = 3'd0; redir_pc = 32'hFFFF_FFFC;
    step();
    redir_valid = 1'b0; redir_taken = 1'b0;
    n_cmp++;
    if (obs_addr !== 12'hFFF) begin
      n_err++;
      $display("FAIL wrap_top: got %h, required fff", obs_addr);
    end
    for (int i = 0; i < NH; i++) begin
      h = m_cnt;
      step();
      if (h == 0) begin
        n_cmp++;
        if (obs_addr !== 12'h000) begin
          n_err++;
          $display("FAIL wrap_zero: got %h, required 000", obs_addr);
        end
      end
    end
    step(); step(); step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (fetch_valid !== 1'b0 || running !== 1'b0 || fetch_pc !== '0) begin
      n_err++;
      $display("FAIL midreset: got v=%b running=%b pc=%h, required 0/0/0", fetch_valid, running, fetch_pc);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs_req !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_idle: got req=%b, required 0", obs_req);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NH; i++) begin
      step();
      n_cmp++;
      if (obs_req !== 1'b1 || obs_addr !== 12'h000) begin
        n_err++;
        $display("FAIL post_reset_pc[%0d]: got req=%b addr=%h, required 1/000", i, obs_req, obs_addr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NH; i++) m_pc[i] = 32'h0;
    test_reset();
    test_sequential();
    test_redirect();
    test_collision();
    test_stall();
    test_misalign();
    test_wrap_reset();
    stall = 1'b1;
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
